// File: rtl/parity_stream_gen_pkg.sv
// Shared types and reset constants for the streaming parity generator/checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } parity_state_t;

  localparam logic RST_IN_READY    = 1'b1;
  localparam logic RST_WORD_VALID  = 1'b0;
  localparam logic RST_WORD_EP     = 1'b0;
  localparam logic RST_WORD_OP     = 1'b0;
  localparam logic RST_FRAME_VALID = 1'b0;
  localparam logic RST_FRAME_EP    = 1'b0;
  localparam logic RST_FRAME_OP    = 1'b1;
  localparam logic RST_WORD_ERR    = 1'b0;

endpackage

// File: rtl/parity_stream_gen_if.sv
// Word stream and result bundle of parity_stream_gen; check signals exist only
// when PARITY_CHECK_EN is defined.
interface parity_stream_gen_if #(
  parameter int DATA_W    = 9,
  parameter int FRAME_LEN = 8,
  parameter int ERR_W     = 8
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              word_valid;
  logic              word_ep;
  logic              word_op;
  logic              frame_valid;
  logic              frame_ep;
  logic              frame_op;
  logic [CNT_W-1:0]  frame_cnt;
`ifdef PARITY_CHECK_EN
  logic              chk_par;
  logic              word_err;
  logic [ERR_W-1:0]  err_cnt;
`endif

  modport master (
    output clr, in_valid, in_data, in_last,
    input  in_ready, word_valid, word_ep, word_op,
    input  frame_valid, frame_ep, frame_op, frame_cnt
`ifdef PARITY_CHECK_EN
    , output chk_par
    , input  word_err, err_cnt
`endif
  );

  modport slave (
    input  clr, in_valid, in_data, in_last,
    output in_ready, word_valid, word_ep, word_op,
    output frame_valid, frame_ep, frame_op, frame_cnt
`ifdef PARITY_CHECK_EN
    , input  chk_par
    , output word_err, err_cnt
`endif
  );

endinterface

// File: rtl/parity_stream_gen_word.sv
// Combinational parity of one word, built as a running XOR chain across the bits.
module parity_word #(
  parameter int DATA_W = 9
) (
  input  logic [DATA_W-1:0] data,
  output logic              ep,
  output logic              op
);

  logic [DATA_W-1:0] chain;

  assign chain[0] = data[0];

  genvar gi;
  generate
    for (gi = 1; gi < DATA_W; gi++) begin : g_chain
      assign chain[gi] = chain[gi-1] ^ data[gi];
    end
  endgenerate

  assign ep = chain[DATA_W-1];
  assign op = ~chain[DATA_W-1];

endmodule

// File: rtl/parity_stream_gen.sv
// Streaming per-word and per-frame parity generator. Define PARITY_CHECK_EN to add
// the received-parity check with its saturating error counter.
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter int DATA_W    = 9,
  parameter int FRAME_LEN = 8,
  parameter int ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_stream_gen_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  parity_state_t    state_reg, state_next;
  logic             acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             word_valid_reg, word_ep_reg, word_op_reg;
  logic             beat_ep, beat_op;
  logic             ready, accept, frame_end;
  logic             frame_valid, frame_ep, frame_op;
  logic [CNT_W-1:0] frame_cnt;

  // One reduction feeds the word result, the frame accumulator and the check.
  parity_word #(.DATA_W(DATA_W)) u_word (
    .data (bus.in_data),
    .ep   (beat_ep),
    .op   (beat_op)
  );

  assign ready     = (state_reg != DONE) && !bus.clr;
  assign accept    = bus.in_valid && ready;
  assign frame_end = accept &&
                     (bus.in_last || (count_reg + CNT_W'(1) == CNT_W'(FRAME_LEN)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_valid = RST_FRAME_VALID;
    frame_ep    = RST_FRAME_EP;
    frame_op    = RST_FRAME_OP;
    frame_cnt   = '0;
    if (bus.clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_end) begin
            state_next = DONE;
          end else if (accept) begin
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (frame_end) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next  = IDLE;
          frame_valid = 1'b1;
          frame_ep    = acc_reg;
          frame_op    = ~acc_reg;
          frame_cnt   = count_reg;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg        <= 1'b0;
      count_reg      <= '0;
      word_valid_reg <= RST_WORD_VALID;
      word_ep_reg    <= RST_WORD_EP;
      word_op_reg    <= RST_WORD_OP;
    end else begin
      word_valid_reg <= accept;
      // No beat is accepted in DONE, so clearing there never drops a word.
      if (bus.clr || state_reg == DONE) begin
        acc_reg   <= 1'b0;
        count_reg <= '0;
      end else if (accept) begin
        acc_reg   <= acc_reg ^ beat_ep;
        count_reg <= count_reg + CNT_W'(1);
      end
      if (accept) begin
        word_ep_reg <= beat_ep;
        word_op_reg <= beat_op;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.word_valid  = word_valid_reg;
  assign bus.word_ep     = word_ep_reg;
  assign bus.word_op     = word_op_reg;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_ep    = frame_ep;
  assign bus.frame_op    = frame_op;
  assign bus.frame_cnt   = frame_cnt;

`ifdef PARITY_CHECK_EN
  logic             word_err_reg;
  logic [ERR_W-1:0] err_cnt_reg;
  logic             beat_err;

  // Even convention: a mismatch between the received bit and the word's XOR.
  assign beat_err = bus.chk_par ^ beat_ep;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_err_reg <= RST_WORD_ERR;
      err_cnt_reg  <= '0;
    end else if (accept) begin
      word_err_reg <= beat_err;
      if (beat_err && err_cnt_reg != {ERR_W{1'b1}}) begin
        err_cnt_reg <= err_cnt_reg + ERR_W'(1);
      end
    end
  end

  assign bus.word_err = word_err_reg;
  assign bus.err_cnt  = err_cnt_reg;
`endif

endmodule

// File: doc/parity_stream_gen.md
# parity_stream_gen

Parametrised streaming parity generator/checker that replaces the fixed 9-bit combinational even/odd parity generator. It accepts a stream of `DATA_W`-bit words over a valid/ready handshake. For each word it produces registered even/odd parity. It also accumulates parity across a frame of up to `FRAME_LEN` words and reports the frame result once at frame end. It sits between a word source (e.g. a UART/serial framer) and its sink, and optionally checks the received parity bits.

## Interface
Parameters:
- `DATA_W`, 9: word width in bits (≥1).
- `FRAME_LEN`, 8: maximum words per frame (≥1); `CNT_W = $clog2(FRAME_LEN+1)`.
- `ERR_W`, 8: width of the saturating error counter (check build only).

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clr`  in  1  synchronous frame abort.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  DATA_W  input word.
- `in_last`  in  1  marks the final word of a short frame.
- `word_valid`  out  1  per-word result valid (1-cycle pulse).
- `word_ep`  out  1  even parity bit of the word, `^in_data`.
- `word_op`  out  1  odd parity bit of the word, `~^in_data`.
- `frame_valid`  out  1  frame result valid (1-cycle pulse).
- `frame_ep` / `frame_op`  out  1  XOR (XNOR) over all bits of all words in the frame.
- `frame_cnt`  out  CNT_W  number of words in the completed frame.
- `chk_par`  in  1  received parity bit for the word (check build only).
- `word_err`  out  1  check failed, aligned with `word_valid` (check build only).
- `err_cnt`  out  ERR_W  saturating count of failed checks (check build only).

## Operation
- FSM states and transitions:
  - IDLE → ACCUM on the first accepted beat.
  - ACCUM → DONE on a beat accepted with `in_last=1` or with count reaching `FRAME_LEN`.
  - DONE → IDLE unconditionally after one cycle.
  - A single-word frame goes IDLE → DONE directly.
- A beat is accepted when `in_valid && in_ready`. `in_ready = (state != DONE) && !clr`.
- Accumulator: `acc <= acc ^ (^in_data)` on each accepted beat. Count increments by 1. Both are cleared on entry to IDLE.
- In DONE:
  - `frame_valid=1`, `frame_ep=acc`, `frame_op=~acc`, `frame_cnt=count`.
  - After DONE, acc and count reset to 0.
- Check:
  - `word_err = chk_par ^ (^in_data)`, i.e. even convention; an odd-parity source must invert `chk_par` upstream.
  - `err_cnt` increments on each `word_err`, saturates at `2^ERR_W-1`, and is cleared only by `rst_n`.
- Boundary conditions:
  - `clr` has priority over `in_valid`. It forces IDLE, zeroes acc and count, suppresses any pending `frame_valid`, and leaves `err_cnt` unchanged.
  - `in_last` in IDLE produces a 1-word frame.
  - `in_last` is ignored when `in_valid=0`.
  - A beat offered while in DONE is stalled (`in_ready=0`) and accepted the following cycle.
- Reset mid-frame: the frame is discarded and every output goes to its reset value.

## Timing
- Reset values:
  - `in_ready=1`.
  - `word_valid`, `word_ep`, `word_op`, `frame_valid`, `frame_ep`, `frame_cnt`, `word_err`, `err_cnt` = 0.
  - `frame_op=1`.
- Per-word latency: 1 cycle from the accepting edge to `word_valid`. `word_ep/op/err` are held until the next accepted beat.
- Frame latency: `frame_valid` asserts the cycle after the last beat, coinciding with that beat's `word_valid`.
- Throughput: one word per cycle within a frame. Exactly one bubble cycle (DONE) between frames.

## Configuration
- `PARITY_CHECK_EN`:
  - Defined: `chk_par`, `word_err`, `err_cnt` exist and checking operates as described.
  - Undefined: those ports and the counter logic are removed. Generation behaviour is identical.

## Structure
- Package `parity_pkg` holds:
  - the state typedef `parity_state_t` {IDLE, ACCUM, DONE};
  - the reset constants.
- Sub-module `parity_word`: purely combinational `DATA_W`-bit reduction giving `ep`/`op`. It is instantiated once and its output is shared by the per-word, accumulator and check paths.

## Test plan
- `DATA_W=9`, single beat `9'b101010101`, `in_last=1` → next cycle `word_ep=1`, `word_op=0`, `frame_valid=1`, `frame_ep=1`, `frame_cnt=1`.
- Frame `9'b101010101`, `9'b010101010`, last → word ep 1 then 0; `frame_ep=1`, `frame_op=0`, `frame_cnt=2`.
- `FRAME_LEN=8`, 8 back-to-back beats of `9'h001` with no `in_last` → `frame_valid` on cycle 9 with `frame_ep=0`, `frame_cnt=8`; `in_ready=0` for that one cycle only.
- `clr` asserted after 3 beats → no `frame_valid`; the next frame of 1 beat `9'h003` gives `frame_ep=0`, `frame_cnt=1`.
- `PARITY_CHECK_EN`: `9'h007` with `chk_par=0` → `word_err=1`, `err_cnt=1`. With `ERR_W=2`, drive 5 errors → `err_cnt` saturates at 3.
- `rst_n` low mid-frame, then high → all outputs at reset values; the next frame starts with `frame_cnt` counting from 1.
